// File: rtl/cnt1_feeder.sv
// Serialises one full fingerprint vector into SUB_VECTOR_NO bus words for the CNT1 stage.
// Words leave least-significant first; bits above VECTOR_WIDTH in the last word are zero.
module cnt1_feeder #(
  parameter int unsigned VECTOR_WIDTH   = 920,
  parameter int unsigned BUS_WIDTH      = 512,
  parameter int unsigned SUB_VECTOR_NO  = 2,
  parameter int unsigned WORD_IDX_WIDTH = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [VECTOR_WIDTH-1:0]   i_Vector,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  input  logic                      i_Stall,
  output logic [BUS_WIDTH-1:0]      o_SubVector,
  output logic                      o_Valid,
  output logic                      o_LastWord,
  output logic [WORD_IDX_WIDTH-1:0] o_WordIdx
);

  localparam int unsigned TotalWidth = SUB_VECTOR_NO * BUS_WIDTH;
  localparam logic [WORD_IDX_WIDTH-1:0] LastIdx = WORD_IDX_WIDTH'(SUB_VECTOR_NO - 1);

  if (!((SUB_VECTOR_NO - 1) * BUS_WIDTH < VECTOR_WIDTH && VECTOR_WIDTH <= TotalWidth))
  begin : g_bad_geometry
    $error("cnt1_feeder: VECTOR_WIDTH does not fit SUB_VECTOR_NO words of BUS_WIDTH");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                    state_q;
  logic [WORD_IDX_WIDTH-1:0] idx_q;
  logic [BUS_WIDTH-1:0]      words_q [SUB_VECTOR_NO];

  logic                  is_last;
  logic                  accept;
  logic [TotalWidth-1:0] vec_ext;
  logic [BUS_WIDTH-1:0]  cur_word;

  // Zero-extend so the padding bits of the last word can never carry ones.
  always_comb begin
    vec_ext                     = '0;
    vec_ext[VECTOR_WIDTH-1:0] = i_Vector;
  end

  always_comb begin
    cur_word = '0;
    for (int unsigned i = 0; i < SUB_VECTOR_NO; i++) begin
      if (idx_q == WORD_IDX_WIDTH'(i)) begin
        cur_word = words_q[i];
      end
    end
  end

  assign is_last     = (idx_q == LastIdx);
  assign o_Ready     = (state_q == StIdle) || ((state_q == StSend) && is_last && !i_Stall);
  assign o_Valid     = (state_q == StSend) && !i_Stall;
  assign o_LastWord  = o_Valid && is_last;
  assign o_WordIdx   = idx_q;
  assign o_SubVector = o_Valid ? cur_word : '0;
  assign accept      = i_Valid && o_Ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int unsigned i = 0; i < SUB_VECTOR_NO; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StSend;
            idx_q   <= '0;
            for (int unsigned i = 0; i < SUB_VECTOR_NO; i++) begin
              words_q[i] <= vec_ext[i*BUS_WIDTH +: BUS_WIDTH];
            end
          end
        end
        StSend: begin
          if (!i_Stall) begin
            if (!is_last) begin
              idx_q <= idx_q + 1'b1;
            end else if (accept) begin
              // Back-to-back: next vector's word 0 follows this last word directly.
              idx_q <= '0;
              for (int unsigned i = 0; i < SUB_VECTOR_NO; i++) begin
                words_q[i] <= vec_ext[i*BUS_WIDTH +: BUS_WIDTH];
              end
            end else begin
              state_q <= StIdle;
              idx_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt1_feeder.sv
// Directed bench for cnt1_feeder: reset, padding, back-to-back, stall, not-ready hold and
// mid-vector reset, with expected words derived from the stimulus vectors.
module tb_cnt1_feeder;

  localparam int unsigned VW = 920;
  localparam int unsigned BW = 512;
  localparam int unsigned SN = 2;
  localparam int unsigned IW = 1;

  logic          clk;
  logic          rst;
  logic [VW-1:0] i_vector;
  logic          i_valid;
  logic          o_ready;
  logic          i_stall;
  logic [BW-1:0] o_sub_vector;
  logic          o_valid;
  logic          o_last_word;
  logic [IW-1:0] o_word_idx;

  int n_checks;
  int n_fail;

  cnt1_feeder #(
    .VECTOR_WIDTH  (VW),
    .BUS_WIDTH     (BW),
    .SUB_VECTOR_NO (SN),
    .WORD_IDX_WIDTH(IW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_Vector   (i_vector),
    .i_Valid    (i_valid),
    .o_Ready    (o_ready),
    .i_Stall    (i_stall),
    .o_SubVector(o_sub_vector),
    .o_Valid    (o_valid),
    .o_LastWord (o_last_word),
    .o_WordIdx  (o_word_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [31:0] pat);
    logic [VW-1:0] v;
    for (int b = 0; b < VW; b++) v[b] = pat[b % 32];
    return v;
  endfunction

  // Reference word j of a vector: LS word first, zero above VW.
  function automatic logic [BW-1:0] wexp(input logic [VW-1:0] v, input int j);
    logic [SN*BW-1:0] t;
    t         = '0;
    t[VW-1:0] = v;
    return t[j*BW +: BW];
  endfunction

  task automatic check_word(input string tag, input logic [VW-1:0] v, input int j);
    check({tag, "_valid"}, BW'(o_valid), BW'(1));
    check({tag, "_data"}, o_sub_vector, wexp(v, j));
    check({tag, "_idx"}, BW'(o_word_idx), BW'(j));
    check({tag, "_last"}, BW'(o_last_word), BW'(j == SN - 1));
    check({tag, "_ready"}, BW'(o_ready), BW'(j == SN - 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, BW'(o_valid), BW'(0));
    check({tag, "_data"}, o_sub_vector, '0);
    check({tag, "_last"}, BW'(o_last_word), BW'(0));
    check({tag, "_ready"}, BW'(o_ready), BW'(1));
  endtask

  logic [VW-1:0] vecs [3];
  logic [VW-1:0] ones_v;
  logic [VW-1:0] c_v;
  logic [BW-1:0] w1_pad;
  int            sel;
  int            popcnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_stall  = 1'b0;
    i_vector = '0;
    vecs[0]  = mkvec(32'hA5C3_0F81);
    vecs[1]  = mkvec(32'h1234_5678);
    vecs[2]  = mkvec(32'hFEDC_BA98);
    ones_v   = '1;
    c_v      = mkvec(32'h0000_000F);
    w1_pad   = '0;
    w1_pad[407:0] = '1;

    #12;
    check_idle("reset");
    check("reset_idx", BW'(o_word_idx), '0);
    rst = 1'b0;

    // Padding: all-ones vector
    cyc();
    i_vector = ones_v;
    i_valid  = 1'b1;
    cyc();
    i_valid = 1'b0;
    #1;
    check("pad_w0", o_sub_vector, '1);
    check("pad_w0_last", BW'(o_last_word), BW'(0));
    cyc();
    #1;
    check("pad_w1", o_sub_vector, w1_pad);
    check("pad_w1_last", BW'(o_last_word), BW'(1));
    cyc();
    #1;
    check_idle("pad_after");

    // Back-to-back: three vectors, six words with no gap
    cyc();
    i_vector = vecs[0];
    i_valid  = 1'b1;
    cyc();
    i_vector = vecs[1];
    sel      = 1;
    for (int t = 0; t < 6; t++) begin
      #1;
      check_word($sformatf("b2b_t%0d", t), vecs[t / 2], t % 2);
      cyc();
      if (t % 2 == 1) begin
        sel++;
        if (sel < 3) i_vector = vecs[sel];
        else i_valid = 1'b0;
      end
    end
    #1;
    check_idle("b2b_after");

    // Stall for three cycles while word 1 is pending
    cyc();
    i_vector = vecs[2];
    i_valid  = 1'b1;
    cyc();
    i_valid = 1'b0;
    #1;
    check_word("stall_w0", vecs[2], 0);
    cyc();
    i_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("stall%0d_valid", s), BW'(o_valid), BW'(0));
      check($sformatf("stall%0d_ready", s), BW'(o_ready), BW'(0));
      check($sformatf("stall%0d_last", s), BW'(o_last_word), BW'(0));
      check($sformatf("stall%0d_data", s), o_sub_vector, '0);
      cyc();
    end
    i_stall = 1'b0;
    #1;
    check_word("stall_w1", vecs[2], 1);
    cyc();
    #1;
    check_idle("stall_after");

    // Not-ready hold: B presented during A's word 0
    cyc();
    i_vector = vecs[0];
    i_valid  = 1'b1;
    cyc();
    i_vector = vecs[1];
    #1;
    check_word("hold_a0", vecs[0], 0);
    cyc();
    #1;
    check_word("hold_a1", vecs[0], 1);
    cyc();
    i_valid = 1'b0;
    #1;
    check_word("hold_b0", vecs[1], 0);
    cyc();
    #1;
    check_word("hold_b1", vecs[1], 1);
    cyc();
    #1;
    check_idle("hold_after");

    // Mid-vector reset after word 0 of A, then vector C
    cyc();
    i_vector = vecs[2];
    i_valid  = 1'b1;
    cyc();
    i_valid = 1'b0;
    #1;
    check_word("mrst_a0", vecs[2], 0);
    #2;
    rst = 1'b1;
    #1;
    check_idle("mrst_async");
    check("mrst_idx", BW'(o_word_idx), '0);
    cyc();
    rst = 1'b0;
    #1;
    check_idle("mrst_no_a1");
    cyc();
    i_vector = c_v;
    i_valid  = 1'b1;
    cyc();
    i_valid = 1'b0;
    popcnt  = 0;
    #1;
    check_word("mrst_c0", c_v, 0);
    popcnt += $countones(o_sub_vector);
    cyc();
    #1;
    check_word("mrst_c1", c_v, 1);
    popcnt += $countones(o_sub_vector);
    // 0xF per 32 bits: 28 full groups plus a 24-bit tail that still holds the nibble.
    check("mrst_c_popcount", BW'(popcnt), BW'(116));
    cyc();
    #1;
    check_idle("mrst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cnt1_feeder.md
# cnt1_feeder

Transmit-side companion of the CNT1 stage. It accepts one full fingerprint vector per upstream handshake and serialises it into `SUB_VECTOR_NO` consecutive `BUS_WIDTH`-bit sub-vector words, in exactly the stream format the CNT1 word counter expects. That format is: every vector emits exactly `SUB_VECTOR_NO` valid words, in order, with zero padding above `VECTOR_WIDTH`. It sits between the vector source (DMA/FIFO) and CNT1. Back-to-back vectors stream at full bus rate.

## Interface

**Parameters**
- `VECTOR_WIDTH`, 920: full fingerprint width in bits.
- `BUS_WIDTH`, 512: sub-vector word width; must match CNT1.
- `SUB_VECTOR_NO`, 2: words per vector. Requires `(SUB_VECTOR_NO-1)*BUS_WIDTH < VECTOR_WIDTH <= SUB_VECTOR_NO*BUS_WIDTH`; an elaboration-time check fails the build otherwise.
- `WORD_IDX_WIDTH`, `$clog2(SUB_VECTOR_NO)` (minimum 1): word index width.

**Ports**
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `i_Vector`, in, `VECTOR_WIDTH`: full input vector.
- `i_Valid`, in, 1: `i_Vector` is valid.
- `o_Ready`, out, 1: the feeder can accept a vector this cycle.
- `i_Stall`, in, 1: downstream hold; pauses emission.
- `o_SubVector`, out, `BUS_WIDTH`: current sub-vector word; connects to CNT1 `i_Vector`.
- `o_Valid`, out, 1: `o_SubVector` is valid; connects to CNT1 `i_Valid`.
- `o_LastWord`, out, 1: the current word is word `SUB_VECTOR_NO-1`.
- `o_WordIdx`, out, `WORD_IDX_WIDTH`: index of the current word.

## Operation

**Registers**
- Holding register `r_Vec` (`SUB_VECTOR_NO*BUS_WIDTH` bits). On accept it loads `i_Vector` zero-extended.
- Word counter `r_Idx`.
- State `r_State`, with values IDLE and SEND.

**Handshake**
- A vector is accepted on a rising edge where `i_Valid && o_Ready`.
- `i_Vector` is ignored when `o_Ready=0`. The source must hold it stable until it is accepted.

**Ready**
- `o_Ready = (r_State==IDLE) || (r_State==SEND && r_Idx==SUB_VECTOR_NO-1 && !i_Stall)`.

**Word output**
- `o_Valid = (r_State==SEND) && !i_Stall`.
- `o_SubVector = r_Vec[r_Idx*BUS_WIDTH +: BUS_WIDTH]` when `o_Valid=1`, otherwise all zeros.
- `o_LastWord = o_Valid && (r_Idx==SUB_VECTOR_NO-1)`.
- `o_WordIdx = r_Idx`.

**Word order and padding**
- Word 0 carries bits `[BUS_WIDTH-1:0]`, least-significant word first.
- Bits at or above `VECTOR_WIDTH` in the last word are always 0, so CNT1 counts no spurious ones.

**State transitions**
- IDLE → SEND on accept; `r_Idx` is set to 0.
- SEND, not stalled, `r_Idx < SUB_VECTOR_NO-1`: `r_Idx` increments.
- SEND, not stalled, last word, accept in the same cycle: stay in SEND, reload `r_Vec`, set `r_Idx` to 0. This is the back-to-back case.
- SEND, not stalled, last word, no accept: go to IDLE; `r_Idx` is set to 0.
- SEND, stalled: all state holds. `o_Valid=0`, so the CNT1 word counter and shift registers do not advance.

**Stream invariant**
- Between any two `o_LastWord` pulses there are exactly `SUB_VECTOR_NO` cycles with `o_Valid=1`.

**Reset**
- Asserting `rst` at any time, including mid-vector, immediately clears state to IDLE and `r_Idx` and `r_Vec` to 0.
- A partial vector is dropped. CNT1 must be reset in the same cycle, because its word counter is not realigned otherwise.

## Timing

**Reset values**
- `o_Valid=0`, `o_LastWord=0`, `o_SubVector=0`, `o_WordIdx=0`.
- `o_Ready=1`, because the state is IDLE.

**Latency**
- A vector accepted at edge k presents word 0 in cycle k+1 (after edge k). Word j is presented in cycle k+1+j plus the number of stall cycles.

**Throughput**
- One vector per `SUB_VECTOR_NO` cycles with no bubbles, provided `i_Valid` is held high and `i_Stall=0`.

**Path type**
- `o_Ready`, `o_Valid` and `o_LastWord` depend combinationally on `i_Stall` and on no other input.
- `o_SubVector` is a mux of registers; there is no path from `i_Vector` to any output.

**Boundary case**
- With `SUB_VECTOR_NO=1`, every word is the last word, `o_Ready` tracks `!i_Stall` while in SEND, and the throughput is one vector per cycle.

## Test plan

All scenarios use `VECTOR_WIDTH=920`, `BUS_WIDTH=512`, `SUB_VECTOR_NO=2` unless stated otherwise.

1. **Reset.** Assert `rst` asynchronously between edges → outputs clear immediately: `o_Valid=0`, `o_SubVector=0`, `o_WordIdx=0`, `o_Ready=1`.
2. **Padding.** Accept an all-ones vector → cycle k+1: word 0 = 512 ones, `o_LastWord=0`. Cycle k+2: word 1 = bits[407:0] all ones, bits[511:408]=0, `o_LastWord=1`. Cycle k+3: `o_Valid=0`.
3. **Back-to-back.** Hold `i_Valid=1` with 3 distinct vectors → 6 consecutive `o_Valid` cycles with no gap, words in order. `o_Ready=1` only on the word-1 cycles; `o_LastWord` pulses in cycles 2, 4 and 6.
4. **Stall.** Assert `i_Stall` for 3 cycles while word 1 is pending → `o_Valid=0` and `o_Ready=0` for 3 cycles. Word 1 is then emitted unchanged, followed by exactly one `o_LastWord`.
5. **Not-ready hold.** Present vector B during vector A's word 0 → B is not accepted. B is accepted on A's word-1 cycle, and B's word 0 follows the next cycle.
6. **Mid-vector reset.** Reset after word 0 of vector A, then send vector C → no word 1 of A appears. C's word 0 is emitted with `o_WordIdx=0`, and a reference-model bit count of C matches CNT1's `o_Cnt`.
